// File: rtl/tdp18k_arb_pkg.sv
// Shared types and latency constants for the TDP18K two-requester port arbiter.
// TDP18K_PORT_ARB_OUTREG_EN adds an output register stage to the read return.
package tdp18k_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_st_e;

`ifdef TDP18K_PORT_ARB_OUTREG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  localparam int BURST_W = 4;

endpackage

// File: rtl/tdp18k_rd_return.sv
// Read-return pipeline: carries the accept tag alongside RAM read data and
// presents it as a one-cycle RVALID pulse after RD_LAT cycles.
module tdp18k_rd_return
  import tdp18k_arb_pkg::*;
#(
  parameter int DATA_W = 18,
  parameter int STAGES = RD_LAT
) (
  input  logic              CLK_i,
  input  logic              RESET_ni,
  input  logic              rd_acc,
  input  logic              rd_tag,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata
);

  logic [STAGES:0]   vld_pipe, tag_pipe;
  logic [STAGES:1]   vld_q, tag_q;
  logic [DATA_W-1:0] ret_data;

  assign vld_pipe = {vld_q, rd_acc};
  assign tag_pipe = {tag_q, rd_tag};

  // Reset flushes the valid bits, so a read in flight never returns.
  always_ff @(posedge CLK_i or negedge RESET_ni) begin
    if (!RESET_ni) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
      tag_q <= tag_pipe[STAGES-1:0];
    end
  end

  generate
    if (STAGES == 1) begin : g_direct
      assign ret_data = ram_rdata;
    end else begin : g_outreg
      logic [DATA_W-1:0] data_q;
      always_ff @(posedge CLK_i or negedge RESET_ni) begin
        if (!RESET_ni) data_q <= '0;
        else           data_q <= ram_rdata;
      end
      assign ret_data = data_q;
    end
  endgenerate

  assign rvalid0 = vld_pipe[STAGES] & ~tag_pipe[STAGES];
  assign rvalid1 = vld_pipe[STAGES] &  tag_pipe[STAGES];
  assign rdata   = vld_pipe[STAGES] ? ret_data : '0;

endmodule

// File: rtl/tdp18k_port_arb.sv
// Two-requester arbiter onto one TDP18K RAM port: round-robin with optional
// locked bursts, combinational grant/command, tagged read return.
// Optional macro: TDP18K_PORT_ARB_OUTREG_EN (read latency 2 instead of 1).
module tdp18k_port_arb
  import tdp18k_arb_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 18,
  parameter int MAX_BURST = 4
) (
  input  logic              CLK_i,
  input  logic              RESET_ni,
  input  logic              REQ0_i,
  input  logic              REQ1_i,
  input  logic              WE0_i,
  input  logic              WE1_i,
  input  logic              LOCK0_i,
  input  logic              LOCK1_i,
  input  logic [ADDR_W-1:0] ADDR0_i,
  input  logic [ADDR_W-1:0] ADDR1_i,
  input  logic [DATA_W-1:0] WDATA0_i,
  input  logic [DATA_W-1:0] WDATA1_i,
  input  logic [1:0]        BE0_i,
  input  logic [1:0]        BE1_i,
  output logic              GNT0_o,
  output logic              GNT1_o,
  output logic              RVALID0_o,
  output logic              RVALID1_o,
  output logic [DATA_W-1:0] RDATA_o,
  output logic              REN_o,
  output logic              WEN_o,
  output logic [ADDR_W-1:0] ADDR_o,
  output logic [DATA_W-1:0] WDATA_o,
  output logic [1:0]        BE_o,
  input  logic [DATA_W-1:0] RAM_RDATA_i
);

  typedef struct packed {
    logic              we;
    logic              lock;
    logic [1:0]        be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  localparam logic [BURST_W-1:0] BURST_MAX = 4'(MAX_BURST);

  arb_st_e            st_q, st_nxt;
  logic               prio_q;
  logic [BURST_W-1:0] burst_q, burst_nxt;
  logic [1:0]         req, gnt;
  logic               acc, acc_id, contend, burst_last;
  cmd_t               cmd0, cmd1, cmd_sel;

  assign req  = {REQ1_i, REQ0_i};
  assign cmd0 = '{we: WE0_i, lock: LOCK0_i, be: BE0_i, addr: ADDR0_i, wdata: WDATA0_i};
  assign cmd1 = '{we: WE1_i, lock: LOCK1_i, be: BE1_i, addr: ADDR1_i, wdata: WDATA1_i};

  assign acc     = |gnt;
  assign acc_id  = gnt[1];
  assign cmd_sel = acc_id ? cmd1 : cmd0;
  assign contend = (st_q == ST_OWN0) ? req[1] : req[0];

  // The IDLE accept that takes ownership is the burst's first; burst_q counts
  // the ones after it, so this accept is the MAX_BURST-th when it is the last.
  assign burst_last = ({1'b0, burst_q} + 5'd2) >= 5'(MAX_BURST);

  always_ff @(posedge CLK_i or negedge RESET_ni) begin
    if (!RESET_ni) begin
      st_q    <= ST_IDLE;
      burst_q <= '0;
      prio_q  <= 1'b0;
    end else begin
      st_q    <= st_nxt;
      burst_q <= burst_nxt;
      if (acc) prio_q <= ~acc_id;
    end
  end

  always_comb begin
    st_nxt    = st_q;
    burst_nxt = burst_q;
    unique case (st_q)
      ST_IDLE: begin
        burst_nxt = '0;
        if (acc && cmd_sel.lock) st_nxt = acc_id ? ST_OWN1 : ST_OWN0;
      end
      ST_OWN0, ST_OWN1: begin
        if (acc && burst_q != BURST_MAX) burst_nxt = burst_q + 4'd1;
        if (!acc || !cmd_sel.lock || (burst_last && contend)) st_nxt = ST_IDLE;
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt = '0;
    unique case (st_q)
      ST_IDLE: gnt = (req == 2'b11) ? (prio_q ? 2'b10 : 2'b01) : req;
      ST_OWN0: gnt[0] = req[0];
      ST_OWN1: gnt[1] = req[1];
      default: gnt = '0;
    endcase
    if (!RESET_ni) gnt = '0;
  end

  assign GNT0_o  = gnt[0];
  assign GNT1_o  = gnt[1];
  assign REN_o   = acc & ~cmd_sel.we;
  assign WEN_o   = acc &  cmd_sel.we;
  assign ADDR_o  = acc ? cmd_sel.addr  : '0;
  assign WDATA_o = acc ? cmd_sel.wdata : '0;
  assign BE_o    = acc ? cmd_sel.be    : '0;

  tdp18k_rd_return #(
    .DATA_W (DATA_W),
    .STAGES (RD_LAT)
  ) u_rd_return (
    .CLK_i     (CLK_i),
    .RESET_ni  (RESET_ni),
    .rd_acc    (REN_o),
    .rd_tag    (acc_id),
    .ram_rdata (RAM_RDATA_i),
    .rvalid0   (RVALID0_o),
    .rvalid1   (RVALID1_o),
    .rdata     (RDATA_o)
  );

endmodule

// File: doc/tdp18k_port_arb.md
TDP18K_PORT_ARB -- requirements
Module: tdp18k_port_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 14: requester and RAM address width.
REQ-002 SHALL have parameter DATA_W, default 18: write and read data width.
REQ-003 SHALL have parameter MAX_BURST, default 4, range 1..15: maximum consecutive locked accepts for one requester.
REQ-004 SHALL have port CLK_i, input, 1: the single clock, shared with the RAM port it drives.
REQ-005 SHALL have port RESET_ni, input, 1: asynchronous active-low reset.
REQ-006 SHALL have ports REQ0_i/REQ1_i, input, 1 each: command request.
REQ-007 SHALL have ports WE0_i/WE1_i, LOCK0_i/LOCK1_i, input, 1 each: write (else read); request burst ownership.
REQ-008 SHALL have ports ADDR0_i/ADDR1_i (ADDR_W), WDATA0_i/WDATA1_i (DATA_W), BE0_i/BE1_i (2), input: command payload.
REQ-009 SHALL have ports GNT0_o/GNT1_o, output, 1 each: command accepted this cycle when REQ&GNT.
REQ-010 SHALL have ports RVALID0_o/RVALID1_o, output, 1 each, and RDATA_o, output, DATA_W: read return.
REQ-011 SHALL have ports REN_o, WEN_o (1), ADDR_o (ADDR_W), WDATA_o (DATA_W), BE_o (2), output: RAM port command.
REQ-012 SHALL have port RAM_RDATA_i, input, DATA_W: RAM read data, valid one cycle after REN_o.

Function
REQ-013 SHALL assert at most one GNTx_o per cycle; GNTx_o is combinational from REQ, owner state and priority pointer.
REQ-014 SHALL drive REN_o=granted&~WE, WEN_o=granted&WE, ADDR_o/BE_o/WDATA_o from the granted requester in the same cycle; with no grant, REN_o=WEN_o=0, ADDR_o=0, WDATA_o=0, BE_o=0.
REQ-015 SHALL arbitrate round-robin when both request and no owner: the requester not granted most recently wins.
REQ-016 SHALL implement FSM IDLE, OWN0, OWN1: IDLE->OWNx on an accept with LOCKx_i=1; OWNx grants x exclusively while REQx_i=1.
REQ-017 SHALL leave OWNx for IDLE when REQx_i=0, when an accept has LOCKx_i=0, or when the burst counter reaches MAX_BURST and the other requester is requesting; that last accept still completes.
REQ-018 SHALL count accepts in OWNx in a 4-bit burst counter, cleared on entering OWNx, saturating at MAX_BURST; without a competing request, ownership persists past MAX_BURST.
REQ-019 SHALL update the priority pointer on every accept to point away from the accepted requester.
REQ-020 SHALL pulse RVALIDx_o exactly one cycle after an accepted read from x, with RDATA_o=RAM_RDATA_i; RDATA_o=0 when no RVALID.
REQ-021 SHALL support back-to-back reads from alternating requesters, one accept per cycle, with returns in accept order.
REQ-022 SHALL give writes no return pulse; a read accepted the cycle after a write to the same address returns the new data, per RAM behaviour.

Reset
REQ-023 SHALL, with RESET_ni=0, force FSM=IDLE, pointer favouring requester 0, burst counter=0, GNT/RVALID/REN/WEN=0, RDATA_o=0.
REQ-024 SHALL drop a read in flight when reset asserts mid-operation: no RVALID after deassertion.

Configuration
REQ-025 SHALL, with macro TDP18K_PORT_ARB_OUTREG_EN defined, register RAM_RDATA_i and the return tag once more, giving read latency 2 and throughput still 1 per cycle.
REQ-026 SHALL, without TDP18K_PORT_ARB_OUTREG_EN, have read latency 1, per REQ-020.

Structure
REQ-027 SHALL place the FSM state enum and latency constants in shared package tdp18k_arb_pkg.
REQ-028 SHALL isolate the read-return pipeline (tag plus data, depth 1 or 2) in sub-module tdp18k_rd_return.

Verification
REQ-029 Reset then REQ0 read ADDR=0x0010 -> GNT0 same cycle, REN_o=1, RVALID0 plus data next cycle (two cycles with OUTREG).
REQ-030 REQ0 and REQ1 reads held 4 cycles, LOCK=0 -> grants 0,1,0,1; RVALID0,1,0,1 in order.
REQ-031 REQ0 with LOCK0=1 held 8 cycles, REQ1 held, MAX_BURST=4 -> 4 GNT0, then GNT1, then REQ0 regains.
REQ-032 Write 0x2AAAA to 0x0100 from 1, read it from 0 next cycle -> RVALID0 with RDATA_o=0x2AAAA, no RVALID1.
REQ-033 RESET_ni low the cycle after a read accept -> no RVALID, all outputs 0, FSM IDLE.
REQ-034 No requests for 10 cycles -> REN/WEN/ADDR/WDATA/BE all 0, no GNT.
